// File: rtl/p_i_cache_ctrl_pkg.sv
// Shared types for the instruction-cache controller.
package rv32i_types;

  // Controller phases: normal lookup, waiting on memory, array write, array re-read.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2,
    REPLAY = 2'd3
  } icache_ctrl_state_t;

endpackage

// File: rtl/p_i_cache_perf.sv
// Hit/miss performance counters; both wrap modulo 2^CNT_W.
module p_i_cache_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_hit,
  input  logic             inc_miss,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;
  logic [CNT_W-1:0] w_one;

  assign w_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count one event per strobe, free-running wrap on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= {CNT_W{1'b0}};
      r_miss_count <= {CNT_W{1'b0}};
    end else begin
      if (inc_hit)  r_hit_count  <= r_hit_count + w_one;
      if (inc_miss) r_miss_count <= r_miss_count + w_one;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: rtl/p_i_cache_ctrl.sv
// Instruction-cache controller: lookup stage, miss handling and line refill.
// Outputs are decoded combinationally from state and inputs.
module p_i_cache_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_read,
  input  logic             imem_flush,
  input  logic             hit,
  input  logic             hit_way,
  input  logic             lru_in,
  input  logic             pmem_resp,
  output logic             pipe_load,
  output logic             imem_resp,
  output logic             pmem_read,
  output logic             array_we,
  output logic             way_sel,
  output logic             lru_we,
  output logic             lru_out,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  icache_ctrl_state_t r_state;
  icache_ctrl_state_t w_state_nxt;
  logic r_stage_valid;
  logic r_flush_pending;
  logic r_victim;

  logic w_pipe_load;
  logic w_imem_resp;
  logic w_pmem_read;
  logic w_array_we;
  logic w_way_sel;
  logic w_lru_we;
  logic w_lru_out;
  logic w_inc_hit;
  logic w_inc_miss;

  // Output decode and next-state selection; a flush in RUN overrides hit and miss.
  always_comb begin
    w_state_nxt = r_state;
    w_pipe_load = 1'b0;
    w_imem_resp = 1'b0;
    w_pmem_read = 1'b0;
    w_array_we  = 1'b0;
    w_way_sel   = 1'b0;
    w_lru_we    = 1'b0;
    w_lru_out   = 1'b0;
    w_inc_hit   = 1'b0;
    w_inc_miss  = 1'b0;
    case (r_state)
      RUN: begin
        if (r_stage_valid && !imem_flush) begin
          if (hit) begin
            w_pipe_load = 1'b1;
            w_imem_resp = 1'b1;
            w_lru_we    = 1'b1;
            w_lru_out   = ~hit_way;
            w_inc_hit   = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_pipe_load = 1'b0;
            w_inc_miss  = 1'b1;
            w_state_nxt = MISS;
          end
        end else begin
          w_pipe_load = 1'b1;
          w_state_nxt = RUN;
        end
      end
      MISS: begin
        w_pmem_read = 1'b1;
        if (pmem_resp) begin
          w_state_nxt = REFILL;
        end else begin
          w_state_nxt = MISS;
        end
      end
      REFILL: begin
        w_array_we  = 1'b1;
        w_way_sel   = r_victim;
        w_state_nxt = REPLAY;
      end
      REPLAY: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lookup-stage valid bit; a flush seen during a miss is deferred until the replay ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_valid   <= 1'b0;
      r_flush_pending <= 1'b0;
    end else if (r_state == REPLAY) begin
      if (r_flush_pending || imem_flush) r_stage_valid <= 1'b0;
      r_flush_pending <= 1'b0;
    end else if (r_state == MISS || r_state == REFILL) begin
      if (imem_flush) r_flush_pending <= 1'b1;
    end else if (w_pipe_load) begin
      r_stage_valid <= imem_read & ~imem_flush;
    end
  end

  // Remember the victim way chosen by LRU at the moment the miss is detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_victim <= 1'b0;
    end else if (w_inc_miss) begin
      r_victim <= lru_in;
    end
  end

  p_i_cache_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_hit    (w_inc_hit),
    .inc_miss   (w_inc_miss),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  assign pipe_load = w_pipe_load;
  assign imem_resp = w_imem_resp;
  assign pmem_read = w_pmem_read;
  assign array_we  = w_array_we;
  assign way_sel   = w_way_sel;
  assign lru_we    = w_lru_we;
  assign lru_out   = w_lru_out;

endmodule

// File: tb/tb_p_i_cache_ctrl.sv
// Scoreboard bench for p_i_cache_ctrl: transaction-level timing model feeds an
// expected-event queue; a negedge monitor pops and compares DUT events.
`timescale 1ns/1ps
module tb_p_i_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_read = 1'b0, imem_flush = 1'b0, hit = 1'b0, hit_way = 1'b0;
  logic lru_in = 1'b0, pmem_resp = 1'b0;

  logic pipe_load, imem_resp, pmem_read, array_we, way_sel, lru_we, lru_out;
  logic [31:0] hit_count, miss_count;
  logic pipe_load_4, imem_resp_4, pmem_read_4, array_we_4, way_sel_4, lru_we_4, lru_out_4;
  logic [3:0] hit_count_4, miss_count_4;

  p_i_cache_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .imem_read(imem_read), .imem_flush(imem_flush),
    .hit(hit), .hit_way(hit_way), .lru_in(lru_in), .pmem_resp(pmem_resp),
    .pipe_load(pipe_load), .imem_resp(imem_resp), .pmem_read(pmem_read),
    .array_we(array_we), .way_sel(way_sel), .lru_we(lru_we), .lru_out(lru_out),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  p_i_cache_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .imem_read(imem_read), .imem_flush(imem_flush),
    .hit(hit), .hit_way(hit_way), .lru_in(lru_in), .pmem_resp(pmem_resp),
    .pipe_load(pipe_load_4), .imem_resp(imem_resp_4), .pmem_read(pmem_read_4),
    .array_we(array_we_4), .way_sel(way_sel_4), .lru_we(lru_we_4), .lru_out(lru_out_4),
    .hit_count(hit_count_4), .miss_count(miss_count_4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int hit_m = 0;
  int miss_m = 0;
  int pm_cnt = 0;

  // kind 0: fetch response (val = expected lru_out); kind 1: refill write (val = way_sel)
  typedef struct {
    int cyc;
    bit kind;
    bit val;
  } ev_t;
  ev_t expq[$];
  ev_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input int c, input bit k, input bit v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    expq.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rd, input bit fl, input bit h, input bit hw,
                       input bit lru, input bit pr);
    imem_read = rd; imem_flush = fl; hit = h; hit_way = hw; lru_in = lru; pmem_resp = pr;
  endtask

  // Monitor: every DUT event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pmem_read) pm_cnt++;
      if (imem_resp) begin
        if (expq.size() == 0) begin
          chk("resp_unexpected", imem_resp, 1'b0);
        end else begin
          mon_e = expq.pop_front();
          chk("resp_kind", mon_e.kind, 1'b0);
          chk("resp_cycle", cyc, mon_e.cyc);
          chk("lru_out", lru_out, mon_e.val);
          chk("lru_we", lru_we, 1'b1);
        end
      end else if (lru_we) begin
        chk("lru_we_spurious", lru_we, 1'b0);
      end
      if (array_we) begin
        if (expq.size() == 0) begin
          chk("refill_unexpected", array_we, 1'b0);
        end else begin
          mon_e = expq.pop_front();
          chk("refill_kind", mon_e.kind, 1'b1);
          chk("refill_cycle", cyc, mon_e.cyc);
          chk("way_sel", way_sel, mon_e.val);
        end
      end
    end
  end

  // n back-to-back hits; fk>0 flushes in burst cycle fk, killing requests fk-1 and fk.
  task automatic hit_burst(input int n, input int fk);
    bit ways[32];
    int c0;
    for (int i = 0; i < n; i++) ways[i] = rb();
    next_cycle();
    c0 = cyc;
    for (int j = 0; j < n; j++) begin
      if (!(fk != 0 && (j == fk - 1 || j == fk))) begin
        push(c0 + j + 1, 1'b0, ~ways[j]);
        hit_m++;
      end
    end
    for (int k = 0; k <= n; k++) begin
      if (k > 0) next_cycle();
      drive(k < n, (fk != 0 && k == fk), (k > 0) ? 1'b1 : rb(),
            (k > 0) ? ways[(k > 0) ? k - 1 : 0] : rb(), rb(), rb());
      if (fk != 0 && k == fk) begin
        #1;
        chk("flush_pipe_load", pipe_load, 1'b1);
        chk("flush_imem_resp", imem_resp, 1'b0);
        chk("flush_lru_we", lru_we, 1'b0);
      end
    end
  endtask

  // One miss: memory answers L cycles after the miss; f>0 flushes at offset f (2..3+L).
  task automatic miss_op(input int L, input bit v, input int f);
    int t;
    next_cycle();
    t = cyc;
    miss_m++;
    push(t + 2 + L, 1'b1, v);
    if (f == 0) begin
      push(t + 4 + L, 1'b0, ~v);
      hit_m++;
    end
    pm_cnt = 0;
    drive(1'b1, 1'b0, rb(), rb(), rb(), rb());
    for (int c = t + 1; c <= t + 4 + L; c++) begin
      next_cycle();
      if (c == t + 1) begin
        drive(1'b0, 1'b0, 1'b0, rb(), v, rb());
        #1;
        chk("miss_pipe_load", pipe_load, 1'b0);
      end else if (c <= t + 1 + L) begin
        drive(rb(), (f != 0 && c == t + f), rb(), rb(), rb(), (c == t + 1 + L));
      end else if (c < t + 4 + L) begin
        drive(rb(), (f != 0 && c == t + f), rb(), rb(), rb(), rb());
      end else begin
        drive(1'b0, 1'b0, 1'b1, v, rb(), rb());
      end
    end
    @(negedge clk);
    #1;
    chk("pmem_read_cycles", pm_cnt, L);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      drive(1'b0, rb(), rb(), rb(), rb(), rb());
    end
  endtask

  task automatic check_counts();
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hit_count", hit_count, hit_m);
    chk("miss_count", miss_count, miss_m);
    chk("hit_count_w4", hit_count_4, hit_m % 16);
    chk("miss_count_w4", miss_count_4, miss_m % 16);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    chk("rst_pipe_load", pipe_load, 1'b1);
    chk("rst_imem_resp", imem_resp, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_array_we", array_we, 1'b0);
    chk("rst_way_sel", way_sel, 1'b0);
    chk("rst_lru_we", lru_we, 1'b0);
    chk("rst_lru_out", lru_out, 1'b0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    hit_burst(4, 0);            // four consecutive hits
    check_counts();
    miss_op(5, 1'b1, 0);        // miss, victim way 1, memory after 5 cycles
    check_counts();
    miss_op(3, 1'b0, 3);        // flush while waiting on memory
    check_counts();
    hit_burst(3, 2);            // flush against a hitting request
    check_counts();
    miss_op(2, 1'b1, 5);        // flush during the replay cycle
    check_counts();

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          int n;
          n = $urandom_range(1, 6);
          hit_burst(n, rb() ? int'($urandom_range(1, n)) : 0);
        end
        1: begin
          int L;
          L = $urandom_range(1, 6);
          miss_op(L, rb(), rb() ? int'($urandom_range(2, 3 + L)) : 0);
        end
        default: idle($urandom_range(1, 3));
      endcase
      check_counts();
    end

    // Reset in the middle of a memory transaction.
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("midmiss_pmem_read", pmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_pmem_read", pmem_read, 1'b0);
    chk("rst_async_hit_count", hit_count, 0);
    chk("rst_async_miss_count", miss_count, 0);
    chk("rst_async_pipe_load", pipe_load, 1'b1);
    hit_m = 0;
    miss_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_pipe_load", pipe_load, 1'b1);
    chk("post_rst_pmem_read", pmem_read, 1'b0);
    check_counts();

    hit_burst(17, 0);           // narrow counters wrap to 1
    check_counts();
    idle(3);

    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
